uart_bram_writer: RTL and testbench
===================================

UART_BRAM_WRITER -- requirements
Module: uart_bram_writer

Interface
REQ-001 Parameter KERNEL_LEN, default 9, number of kernel bytes received first.
REQ-002 Parameter IMAGE_LEN, default 50176, number of image bytes received after the kernel.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clock clk.
REQ-005 start  input  1  one-cycle pulse arming a new load.
REQ-006 rx_valid  input  1  one-cycle strobe from UART receiver, byte available.
REQ-007 rx_data  input  8  received byte, valid only when rx_valid=1.
REQ-008 kernel_we  output  1  kernel BRAM write enable, one cycle per byte.
REQ-009 kernel_addr  output  4  kernel BRAM write address.
REQ-010 kernel_din  output  8  kernel BRAM write data.
REQ-011 image_we  output  1  image BRAM write enable, one cycle per byte.
REQ-012 image_addr  output  16  image BRAM write address.
REQ-013 image_din  output  8  image BRAM write data.
REQ-014 image_write_count  output  16  number of image bytes written this load.
REQ-015 kernel_loaded  output  1  sticky; all KERNEL_LEN kernel bytes written.
REQ-016 write_complete  output  1  sticky; all IMAGE_LEN image bytes written.
REQ-017 extra_byte  output  1  sticky; a byte arrived in DONE state and was discarded.

Function
REQ-018 FSM states SHALL be IDLE, KERNEL, IMAGE, DONE.
REQ-019 IDLE->KERNEL on start=1; rx_valid in IDLE ignored, including the cycle start is high.
REQ-020 start in KERNEL, IMAGE or DONE SHALL be ignored; only reset rearms.
REQ-021 KERNEL: rx_valid at edge N -> kernel_we=1 at N+1 for exactly one cycle, kernel_addr=kernel byte index (0..KERNEL_LEN-1), kernel_din=rx_data.
REQ-022 Capture of byte index KERNEL_LEN-1 -> state IMAGE and kernel_loaded=1 both from N+1.
REQ-023 IMAGE: rx_valid at edge N -> image_we=1 at N+1 for one cycle, image_addr=image byte index (0..IMAGE_LEN-1), image_din=rx_data, image_write_count incremented at N+1.
REQ-024 Capture of image byte IMAGE_LEN-1 -> state DONE and write_complete=1 from N+1, same cycle as the final image_we.
REQ-025 Back-to-back rx_valid on consecutive cycles SHALL each produce one write; no byte is lost or duplicated.
REQ-026 image_we and kernel_we SHALL never be high in the same cycle.
REQ-027 Address outputs SHALL hold their last value when the corresponding we=0.
REQ-028 DONE: rx_valid sets extra_byte=1 next cycle; no write issued; counters unchanged.
REQ-029 Byte counters SHALL never exceed KERNEL_LEN-1 / IMAGE_LEN-1 as addresses; no wrap-around to 0 within a load.
REQ-030 rx_data SHALL be stored unmodified (no sign or clamp processing).

Reset
REQ-031 Reset asserted at any time, including mid-load, SHALL immediately force IDLE.
REQ-032 Reset values: all we=0, all addresses 0, all din 0, image_write_count 0, kernel_loaded 0, write_complete 0, extra_byte 0.
REQ-033 After reset deassertion a new start SHALL begin a fresh load at kernel address 0.

Verification
REQ-034 Reset, start, 9 bytes 0x01..0x09 every 16 cycles -> kernel_we pulses at addr 0..8 with data 0x01..0x09, kernel_loaded=1 after ninth, no image_we.
REQ-035 Full load, image byte k = k[7:0] -> 50176 image_we pulses, image_addr=k, image_write_count=50176 and write_complete=1 one cycle after last rx_valid.
REQ-036 rx_valid with rx_data=0xAA in IDLE (with and without start same cycle) -> no write, counters 0.
REQ-037 Two rx_valid on consecutive cycles in IMAGE (0x11, 0x22) -> image_we high two consecutive cycles, consecutive addresses, data 0x11 then 0x22.
REQ-038 After write_complete, one more rx_valid -> extra_byte=1, no write, image_write_count stays 50176.
REQ-039 Reset asserted after 100 image bytes, then start and reload -> kernel restarts at addr 0, image at addr 0, image_write_count counts from 0.

Source files
------------

// File: rtl/uart_bram_writer.sv
// UART-to-BRAM loader.
// After a start pulse, the first KERNEL_LEN received bytes are written to the
// kernel BRAM and the following IMAGE_LEN bytes to the image BRAM, one write
// per received byte. Every output is registered. Once the load is complete,
// the block stays in DONE and only reset can rearm it.
module uart_bram_writer #(
   parameter int KERNEL_LEN = 9,
   parameter int IMAGE_LEN  = 50176
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        kernel_we,
   output logic [3:0]  kernel_addr,
   output logic [7:0]  kernel_din,
   output logic        image_we,
   output logic [15:0] image_addr,
   output logic [7:0]  image_din,
   output logic [15:0] image_write_count,
   output logic        kernel_loaded,
   output logic        write_complete,
   output logic        extra_byte
);

   typedef enum logic [1:0] {
      IDLE,
      KERNEL,
      IMAGE,
      DONE
   } state_t;

   localparam logic [3:0]  KERNEL_LAST = 4'(KERNEL_LEN - 1);
   localparam logic [15:0] IMAGE_LAST  = 16'(IMAGE_LEN - 1);

   state_t      r_state;
   logic [3:0]  r_kernelIdx;
   logic [15:0] r_imageCount;
   logic        r_kernelWe;
   logic [3:0]  r_kernelAddr;
   logic [7:0]  r_kernelDin;
   logic        r_imageWe;
   logic [15:0] r_imageAddr;
   logic [7:0]  r_imageDin;
   logic        r_kernelLoaded;
   logic        r_writeComplete;
   logic        r_extraByte;

   logic w_kernelLast;
   logic w_imageLast;

   // The image byte count doubles as the index of the next image byte, so the
   // final byte is recognised before the counter reaches IMAGE_LEN.
   assign w_kernelLast = (r_kernelIdx == KERNEL_LAST);
   assign w_imageLast  = (r_imageCount == IMAGE_LAST);

   // Load sequencer: a single process for state, byte indices, write strobes and sticky flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_kernelIdx     <= '0;
         r_imageCount    <= '0;
         r_kernelWe      <= 1'b0;
         r_kernelAddr    <= '0;
         r_kernelDin     <= '0;
         r_imageWe       <= 1'b0;
         r_imageAddr     <= '0;
         r_imageDin      <= '0;
         r_kernelLoaded  <= 1'b0;
         r_writeComplete <= 1'b0;
         r_extraByte     <= 1'b0;
      end else begin
         r_kernelWe <= 1'b0;
         r_imageWe  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= KERNEL;
               end
            end
            KERNEL: begin
               if (rx_valid) begin
                  r_kernelWe   <= 1'b1;
                  r_kernelAddr <= r_kernelIdx;
                  r_kernelDin  <= rx_data;
                  if (w_kernelLast) begin
                     r_state        <= IMAGE;
                     r_kernelLoaded <= 1'b1;
                  end else begin
                     r_kernelIdx <= r_kernelIdx + 4'd1;
                  end
               end
            end
            IMAGE: begin
               if (rx_valid) begin
                  r_imageWe    <= 1'b1;
                  r_imageAddr  <= r_imageCount;
                  r_imageDin   <= rx_data;
                  r_imageCount <= r_imageCount + 16'd1;
                  if (w_imageLast) begin
                     r_state         <= DONE;
                     r_writeComplete <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (rx_valid) begin
                  r_extraByte <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign kernel_we         = r_kernelWe;
   assign kernel_addr       = r_kernelAddr;
   assign kernel_din        = r_kernelDin;
   assign image_we          = r_imageWe;
   assign image_addr        = r_imageAddr;
   assign image_din         = r_imageDin;
   assign image_write_count = r_imageCount;
   assign kernel_loaded     = r_kernelLoaded;
   assign write_complete    = r_writeComplete;
   assign extra_byte        = r_extraByte;

endmodule

// File: tb/tb_uart_bram_writer.sv
// Testbench for uart_bram_writer.
// A byte-counting reference model predicts every output on each clock. Three
// loads are exercised: a full-length load, a load that reset aborts, and a
// fresh reload. Hand-computed literal checks pin key points of each load.
`timescale 1ns/1ps
module tb_uart_bram_writer;

   localparam int KLEN = 9;
   localparam int ILEN = 50176;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        kernel_we;
   logic [3:0]  kernel_addr;
   logic [7:0]  kernel_din;
   logic        image_we;
   logic [15:0] image_addr;
   logic [7:0]  image_din;
   logic [15:0] image_write_count;
   logic        kernel_loaded;
   logic        write_complete;
   logic        extra_byte;

   int total = 0;
   int bad = 0;

   // Reference model state: the load is armed, then bytes are counted.
   bit         mArmed = 1'b0;
   int         mKCount = 0;
   int         mICount = 0;
   bit         mKWe = 1'b0;
   int         mKAddr = 0;
   logic [7:0] mKDin = 8'h00;
   bit         mIWe = 1'b0;
   int         mIAddr = 0;
   logic [7:0] mIDin = 8'h00;
   bit         mExtra = 1'b0;

   uart_bram_writer #(
      .KERNEL_LEN(KLEN),
      .IMAGE_LEN (ILEN)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .kernel_we        (kernel_we),
      .kernel_addr      (kernel_addr),
      .kernel_din       (kernel_din),
      .image_we         (image_we),
      .image_addr       (image_addr),
      .image_din        (image_din),
      .image_write_count(image_write_count),
      .kernel_loaded    (kernel_loaded),
      .write_complete   (write_complete),
      .extra_byte       (extra_byte)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, then advance to the next edge plus 1 ns.
   task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d);
      start    = s;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Reference model: the first KLEN bytes after start go to the kernel, the next ILEN to the image, and any later byte is discarded.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mArmed  = 1'b0;
         mKCount = 0;
         mICount = 0;
         mKWe    = 1'b0;
         mKAddr  = 0;
         mKDin   = 8'h00;
         mIWe    = 1'b0;
         mIAddr  = 0;
         mIDin   = 8'h00;
         mExtra  = 1'b0;
      end else begin
         mKWe = 1'b0;
         mIWe = 1'b0;
         if (!mArmed) begin
            if (start) mArmed = 1'b1;
         end else if (rx_valid) begin
            if (mKCount < KLEN) begin
               mKWe   = 1'b1;
               mKAddr = mKCount;
               mKDin  = rx_data;
               mKCount++;
            end else if (mICount < ILEN) begin
               mIWe   = 1'b1;
               mIAddr = mICount;
               mIDin  = rx_data;
               mICount++;
            end else begin
               mExtra = 1'b1;
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      checkOutput("kernel_we", 32'(kernel_we), 32'(mKWe));
      checkOutput("image_we", 32'(image_we), 32'(mIWe));
      checkOutput("we_exclusive", 32'(kernel_we & image_we), 32'd0);
      checkOutput("kernel_addr", 32'(kernel_addr), 32'(mKAddr));
      checkOutput("image_addr", 32'(image_addr), 32'(mIAddr));
      if (mKWe) checkOutput("kernel_din", 32'(kernel_din), 32'(mKDin));
      if (mIWe) checkOutput("image_din", 32'(image_din), 32'(mIDin));
      checkOutput("image_write_count", 32'(image_write_count), 32'(mICount));
      checkOutput("kernel_loaded", 32'(kernel_loaded), 32'(mKCount == KLEN));
      checkOutput("write_complete", 32'(write_complete), 32'(mICount == ILEN));
      checkOutput("extra_byte", 32'(extra_byte), 32'(mExtra));
   end

   // Watchdog: stop a run that never finishes.
   initial begin
      #3_000_000;
      bad++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      int imgSent;
      logic [15:0] kIdx;

      // Check the reset values while reset is held.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_kernel_we", 32'(kernel_we), 32'd0);
      checkOutput("rst_image_addr", 32'(image_addr), 32'd0);
      checkOutput("rst_kernel_din", 32'(kernel_din), 32'd0);
      checkOutput("rst_image_din", 32'(image_din), 32'd0);
      checkOutput("rst_flags", {29'd0, kernel_loaded, write_complete, extra_byte}, 32'd0);
      reset = 1'b0;

      // Bytes received in IDLE are ignored, including one that arrives with start.
      applyStimulus(1'b0, 1'b1, 8'hAA);
      checkOutput("idle_kernel_we", 32'(kernel_we), 32'd0);
      applyStimulus(1'b1, 1'b1, 8'hAA);
      checkOutput("idle_start_kernel_we", 32'(kernel_we), 32'd0);
      checkOutput("idle_count", 32'(image_write_count), 32'd0);

      // Kernel bytes 0x01..0x09, one every 16 cycles.
      for (int k = 1; k <= KLEN; k++) begin
         applyStimulus(1'b0, 1'b1, 8'(k));
         checkOutput("k_we_lit", 32'(kernel_we), 32'd1);
         checkOutput("k_addr_lit", 32'(kernel_addr), 32'(k - 1));
         checkOutput("k_din_lit", 32'(kernel_din), 32'(k));
         checkOutput("k_loaded_lit", 32'(kernel_loaded), 32'(k == KLEN));
         repeat (15) applyStimulus(1'b0, 1'b0, 8'($urandom));
      end

      // Full image load: byte k carries k[7:0], mostly back-to-back, with random gaps and stray start pulses.
      for (int k = 0; k < ILEN; k++) begin
         if ($urandom_range(15) == 0)
            applyStimulus(1'($urandom_range(3) == 0), 1'b0, 8'($urandom));
         kIdx = 16'(k);
         applyStimulus(1'b0, 1'b1, kIdx[7:0]);
      end
      checkOutput("full_count_lit", 32'(image_write_count), 32'd50176);
      checkOutput("full_complete_lit", 32'(write_complete), 32'd1);
      checkOutput("full_last_addr_lit", 32'(image_addr), 32'd50175);
      checkOutput("full_last_din_lit", 32'(image_din), 32'hFF);

      // A byte arriving after completion is discarded, and start is ignored in DONE.
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h5A);
      checkOutput("extra_byte_lit", 32'(extra_byte), 32'd1);
      checkOutput("extra_no_we", 32'({kernel_we, image_we}), 32'd0);
      checkOutput("extra_count_lit", 32'(image_write_count), 32'd50176);
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

      // Reset ends the full load; its effect must be visible without a clock edge.
      reset = 1'b1;
      #1;
      checkOutput("rst1_flags", {29'd0, kernel_loaded, write_complete, extra_byte}, 32'd0);
      checkOutput("rst1_count", 32'(image_write_count), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Second load: random kernel and image data with random gaps, aborted by reset after 100 image bytes.
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < KLEN; k++) begin
         if ($urandom_range(3) == 0)
            applyStimulus(1'($urandom_range(1)), 1'b0, 8'($urandom));
         applyStimulus(1'b0, 1'b1, 8'($urandom));
      end
      imgSent = 0;
      while (imgSent < 100) begin
         if ($urandom_range(3) == 0) begin
            applyStimulus(1'($urandom_range(1)), 1'b0, 8'($urandom));
         end else begin
            applyStimulus(1'b0, 1'b1, 8'($urandom));
            imgSent++;
         end
      end
      checkOutput("mid_count_lit", 32'(image_write_count), 32'd100);
      reset = 1'b1;
      #1;
      checkOutput("rst2_we", 32'({kernel_we, image_we}), 32'd0);
      checkOutput("rst2_addrs", {kernel_addr, image_addr}, 32'd0);
      checkOutput("rst2_count", 32'(image_write_count), 32'd0);
      checkOutput("rst2_flags", {29'd0, kernel_loaded, write_complete, extra_byte}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Third load starts fresh at address 0 for both memories.
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h3C);
      checkOutput("reload_k_addr_lit", 32'(kernel_addr), 32'd0);
      checkOutput("reload_k_din_lit", 32'(kernel_din), 32'h3C);
      for (int k = 1; k < KLEN; k++) applyStimulus(1'b0, 1'b1, 8'($urandom));
      checkOutput("reload_k_loaded_lit", 32'(kernel_loaded), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h11);
      checkOutput("b2b_we0_lit", 32'(image_we), 32'd1);
      checkOutput("b2b_addr0_lit", 32'(image_addr), 32'd0);
      checkOutput("b2b_din0_lit", 32'(image_din), 32'h11);
      checkOutput("b2b_count0_lit", 32'(image_write_count), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h22);
      checkOutput("b2b_we1_lit", 32'(image_we), 32'd1);
      checkOutput("b2b_addr1_lit", 32'(image_addr), 32'd1);
      checkOutput("b2b_din1_lit", 32'(image_din), 32'h22);
      checkOutput("b2b_count1_lit", 32'(image_write_count), 32'd2);
      for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'($urandom_range(1)), 8'($urandom));
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
